key_event_ctrl: RTL and testbench

KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

---
 rtl/key_event_ctrl_pkg.sv | 15 +
 rtl/key_evt_fifo.sv | 41 ++++
 rtl/key_event_ctrl.sv | 110 +++++++++++
 tb/tb_key_event_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/key_event_ctrl_pkg.sv
// key_event_ctrl_pkg: shared event codes, widths, FSM states and helpers for key_event_ctrl
package key_event_ctrl_pkg;
  localparam int KEY_W = 3;
  localparam int FIFO_DEPTH = 4;
  typedef enum logic [1:0] {EVT_SHORT = 2'd0, EVT_LONG = 2'd1, EVT_REPEAT = 2'd2} evt_type_e;
  typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_LONG_HELD} state_e;
  typedef struct packed {
    logic [KEY_W-1:0] key;
    evt_type_e        typ;
  } evt_t;
  function automatic logic [KEY_W-1:0] lowest_idx(input logic [7:0] v);
    lowest_idx = '0;
    for (int i = 7; i >= 0; i--) if (v[i]) lowest_idx = KEY_W'(i);
  endfunction
endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: 4-deep in-order event queue; push/pop in, head/full/empty/drop out
module key_evt_fifo
  import key_event_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t push_data,
  input  logic pop,
  output evt_t head,
  output logic full,
  output logic empty,
  output logic drop
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  evt_t          r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_pop, w_wr;
  assign full  = r_cnt == DEPTH_C;
  assign empty = r_cnt == '0;
  assign w_pop = pop & ~empty;
  assign w_wr  = push & (~full | w_pop);
  assign drop  = push & full & ~w_pop;
  assign head  = r_mem[r_rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) r_mem[r_wp] <= push_data;
      r_wp  <= w_wr ? r_wp + 1'b1 : r_wp;
      r_rp  <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt <= (w_wr & ~w_pop) ? r_cnt + 1'b1 : ((~w_wr & w_pop) ? r_cnt - 1'b1 : r_cnt);
    end
  end
endmodule

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: turns debounced key levels into queued SHORT/LONG/REPEAT events
module key_event_ctrl
  import key_event_ctrl_pkg::*;
#(
  parameter int NUM_KEYS  = 5,
  parameter int TICK_DIV  = 100000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_lvl,
  input  logic                evt_ready,
  input  logic                ovf_clr,
  output logic                evt_valid,
  output logic [KEY_W-1:0]    evt_key,
  output logic [1:0]          evt_type,
  output logic                overflow
);
  localparam int MS_MAX = LONG_MS > REPEAT_MS ? LONG_MS : REPEAT_MS;
  localparam int MW = $clog2(MS_MAX + 1);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MS_LONG = MW'(LONG_MS);
  localparam logic [MW-1:0] MS_REP = MW'(REPEAT_MS);
  localparam logic [MW-1:0] MS_SAT = MW'(MS_MAX);
  state_e              r_state, w_state_nxt;
  logic [NUM_KEYS-1:0] r_prev;
  logic [KEY_W-1:0]    r_key;
  logic [PW-1:0]       r_pre;
  logic [MW-1:0]       r_ms;
  logic                r_ovf;
  logic [7:0]          w_lvl8, w_press8;
  logic                w_held, w_tick, w_acq, w_push, w_ms_clr;
  evt_type_e           w_typ;
  evt_t                w_head;
  logic                w_full, w_empty, w_drop;
  assign w_lvl8   = 8'(key_lvl);
  assign w_press8 = w_lvl8 & ~8'(r_prev);
  assign w_held   = w_lvl8[r_key];
  assign w_tick   = r_pre == PRE_LAST;
  always_comb begin
    w_state_nxt = r_state;
    w_acq       = 1'b0;
    w_push      = 1'b0;
    w_ms_clr    = 1'b0;
    w_typ       = EVT_SHORT;
    case (r_state)
      ST_IDLE: begin
        w_acq       = |w_press8;
        w_state_nxt = w_acq ? ST_HELD : ST_IDLE;
      end
      // release is tested before the threshold so it wins when both land together
      ST_HELD: begin
        if (!w_held) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_ms == MS_LONG) begin
          w_push      = 1'b1;
          w_typ       = EVT_LONG;
          w_ms_clr    = 1'b1;
          w_state_nxt = ST_LONG_HELD;
        end
      end
      ST_LONG_HELD: begin
        if (!w_held) w_state_nxt = ST_IDLE;
        else if (r_ms == MS_REP) begin
          w_push   = 1'b1;
          w_typ    = EVT_REPEAT;
          w_ms_clr = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_prev  <= '0;
      r_key   <= '0;
      r_pre   <= '0;
      r_ms    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prev  <= key_lvl;
      r_key   <= w_acq ? lowest_idx(w_press8) : r_key;
      r_pre   <= (w_acq || w_tick || r_state == ST_IDLE) ? '0 : r_pre + 1'b1;
      r_ms    <= (w_acq || w_ms_clr || r_state == ST_IDLE) ? '0 :
                 ((w_tick && r_ms != MS_SAT) ? r_ms + 1'b1 : r_ms);
      r_ovf   <= w_drop ? 1'b1 : (ovf_clr ? 1'b0 : r_ovf);
    end
  end
  key_evt_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_data('{key: r_key, typ: w_typ}),
    .pop      (evt_ready),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .drop     (w_drop)
  );
  always_ff @(posedge clk) if (rst_n) assert (!w_drop || w_full);
  assign evt_valid = ~w_empty;
  assign evt_key   = w_head.key;
  assign evt_type  = w_head.typ;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed self-checking bench with a timing-formula event model
module tb_key_event_ctrl;
  localparam int DIV = 10;
  localparam int LMS = 5;
  localparam int RMS = 2;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] key_lvl = '0;
  logic       evt_ready = 1'b1;
  logic       ovf_clr = 1'b0;
  logic       evt_valid, overflow;
  logic [2:0] evt_key;
  logic [1:0] evt_type;
  always #5 clk = ~clk;
  key_event_ctrl #(.NUM_KEYS(5), .TICK_DIV(DIV), .LONG_MS(LMS), .REPEAT_MS(RMS)) dut (
    .clk(clk), .rst_n(rst_n), .key_lvl(key_lvl), .evt_ready(evt_ready), .ovf_clr(ovf_clr),
    .evt_valid(evt_valid), .evt_key(evt_key), .evt_type(evt_type), .overflow(overflow)
  );
  typedef struct {int key; int typ; int e;} ev_t;
  int checks = 0;
  int passes = 0;
  int edge_n = 0;
  int s_ref = 0;
  ev_t mq[$];
  ev_t popped[$];
  bit m_ovf, m_act, m_long, m_push, m_pop, m_drop;
  logic [4:0] m_prev, m_press;
  int m_key, m_t0, m_nrep, m_dt, m_typ;
  ev_t m_tmp;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask
  // Model: an event is due at a fixed number of edges after the press edge;
  // LONG at LMS*DIV+1, the j-th REPEAT at (LMS+j*RMS)*DIV+1, a release first gives SHORT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0; m_prev = '0; m_act = 0; m_long = 0;
    end else begin
      edge_n++;
      m_press = key_lvl & ~m_prev;
      m_pop = mq.size() > 0 && evt_ready;
      m_push = 0;
      m_typ = 0;
      if (!m_act) begin
        if (m_press != 0) begin
          m_act = 1; m_long = 0; m_nrep = 0; m_t0 = edge_n;
          for (int i = 4; i >= 0; i--) if (m_press[i]) m_key = i;
        end
      end else begin
        m_dt = edge_n - m_t0;
        if (!key_lvl[m_key]) begin
          m_push = !m_long;
          m_act = 0;
        end else if (!m_long && m_dt == LMS * DIV + 1) begin
          m_push = 1; m_typ = 1; m_long = 1;
        end else if (m_long && m_dt == (LMS + (m_nrep + 1) * RMS) * DIV + 1) begin
          m_push = 1; m_typ = 2; m_nrep++;
        end
      end
      m_drop = m_push && mq.size() == 4 && !m_pop;
      if (m_pop) begin
        m_tmp = mq.pop_front();
        m_tmp.e = edge_n;
        popped.push_back(m_tmp);
      end
      if (m_push && !m_drop) begin
        m_tmp.key = m_key; m_tmp.typ = m_typ; m_tmp.e = 0;
        mq.push_back(m_tmp);
      end
      m_ovf = m_drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      m_prev = key_lvl;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", int'(evt_valid), 0);
      chk("rst_ovf", int'(overflow), 0);
      chk("rst_key", int'(evt_key), 0);
      chk("rst_type", int'(evt_type), 0);
    end else begin
      chk("valid", int'(evt_valid), mq.size() > 0 ? 1 : 0);
      if (mq.size() > 0) begin
        chk("head_key", int'(evt_key), mq[0].key);
        chk("head_type", int'(evt_type), mq[0].typ);
      end
      chk("ovf", int'(overflow), int'(m_ovf));
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic press(input int k, input int hi, input int lo);
    key_lvl = 5'(1 << k);
    cyc(hi);
    key_lvl = '0;
    cyc(lo);
  endtask
  task automatic begin_test;
    popped.delete();
    s_ref = edge_n;
  endtask
  task automatic check_ev(input string n, input int i, input int k, input int t, input int rel);
    if (popped.size() > i) begin
      chk({n, "_key"}, popped[i].key, k);
      chk({n, "_type"}, popped[i].typ, t);
      if (rel >= 0) chk({n, "_edge"}, popped[i].e - s_ref, rel);
    end else chk({n, "_missing"}, popped.size(), i + 1);
  endtask
  initial begin
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    begin_test;
    key_lvl = 5'b00100; cyc(30); key_lvl = '0; cyc(10);
    chk("short_cnt", popped.size(), 1);
    check_ev("short", 0, 2, 0, 32);
    begin_test;
    key_lvl = 5'b00001; cyc(100); key_lvl = '0; cyc(20);
    chk("long_cnt", popped.size(), 3);
    check_ev("long", 0, 0, 1, 53);
    check_ev("rep1", 1, 0, 2, 73);
    check_ev("rep2", 2, 0, 2, 93);
    begin_test;
    key_lvl = 5'b01010; cyc(30); key_lvl = 5'b01000; cyc(30); key_lvl = '0; cyc(5);
    chk("multi_cnt", popped.size(), 1);
    check_ev("multi", 0, 1, 0, 32);
    begin_test;
    key_lvl = 5'b00100; cyc(51); key_lvl = '0; cyc(10);
    chk("tie_cnt", popped.size(), 1);
    check_ev("tie", 0, 2, 0, 53);
    begin_test;
    key_lvl = 5'b00100; cyc(52); key_lvl = '0; cyc(10);
    chk("post_tie_cnt", popped.size(), 1);
    check_ev("post_tie", 0, 2, 1, 53);
    begin_test;
    evt_ready = 1'b0;
    press(4, 3, 3); press(3, 3, 3); press(2, 3, 3); press(1, 3, 3); press(0, 3, 3); press(4, 3, 3);
    chk("full_ovf", int'(overflow), 1);
    chk("full_valid", int'(evt_valid), 1);
    chk("full_head", int'(evt_key), 4);
    key_lvl = 5'b00010; cyc(3); key_lvl = '0; ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0; cyc(2);
    chk("drop_beats_clr", int'(overflow), 1);
    ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    chk("stall_cnt", popped.size(), 0);
    evt_ready = 1'b1; cyc(8);
    chk("drain_cnt", popped.size(), 4);
    check_ev("drain0", 0, 4, 0, -1);
    check_ev("drain1", 1, 3, 0, -1);
    check_ev("drain2", 2, 2, 0, -1);
    check_ev("drain3", 3, 1, 0, -1);
    begin_test;
    evt_ready = 1'b0;
    press(0, 3, 3); press(1, 3, 3); press(2, 3, 3); press(3, 3, 3);
    key_lvl = 5'b10000; cyc(3); key_lvl = '0; evt_ready = 1'b1; cyc(1); evt_ready = 1'b0; cyc(2);
    chk("pushpop_ovf", int'(overflow), 0);
    chk("pushpop_one", popped.size(), 1);
    evt_ready = 1'b1; cyc(8);
    chk("pushpop_cnt", popped.size(), 5);
    check_ev("pushpop0", 0, 0, 0, -1);
    check_ev("pushpop4", 4, 4, 0, -1);
    evt_ready = 1'b0;
    press(0, 3, 3); press(1, 3, 3); press(2, 3, 3); press(3, 3, 3); press(4, 3, 3);
    evt_ready = 1'b1; cyc(6);
    evt_ready = 1'b0;
    key_lvl = 5'b00001; cyc(80);
    chk("pre_rst_ovf", int'(overflow), 1);
    chk("pre_rst_type", int'(evt_type), 1);
    chk("pre_rst_queued", mq.size(), 2);
    key_lvl = '0; rst_n = 1'b0; #1;
    chk("async_valid", int'(evt_valid), 0);
    chk("async_ovf", int'(overflow), 0);
    chk("async_type", int'(evt_type), 0);
    cyc(2);
    rst_n = 1'b1;
    begin_test;
    evt_ready = 1'b1; cyc(40);
    chk("post_rst_cnt", popped.size(), 0);
    chk("post_rst_valid", int'(evt_valid), 0);
    rst_n = 1'b0; key_lvl = 5'b00010; cyc(2);
    rst_n = 1'b1;
    begin_test;
    cyc(20); key_lvl = '0; cyc(10);
    chk("held_rst_cnt", popped.size(), 1);
    check_ev("held_rst", 0, 1, 0, 22);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
